csa_resolve_serial: RTL and testbench



---
 rtl/csa_resolve_serial.sv | 92 +++++++++
 tb/tb_csa_resolve_serial.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve_serial.sv
// Word-serial carry-propagate adder that resolves a carry-save pair (s0, s1) into a binary sum.
// It adds W bits per enabled cycle and hands the sum and carry-out over a valid/ready handshake.
module csa_resolve_serial #(
  parameter int unsigned K = 2 + 1024 + 1,
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] s0,
  input  logic [K-1:0] s1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] sum,
  output logic         cout
);

  localparam int unsigned N  = (K + W - 1) / W;
  localparam int unsigned NW = N * W;
  localparam int unsigned L  = K - (N - 1) * W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t        state;
  logic [NW-1:0] a_q;
  logic [NW-1:0] b_q;
  logic [NW-1:0] res_q;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [W:0]    chunk;

  // Low chunk sum; the zero-padded operands make bit L of the last chunk the carry out of bit K-1.
  assign chunk = (W+1)'(a_q[W-1:0]) + (W+1)'(b_q[W-1:0]) + (W+1)'(carry);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (ce) begin
      if (clr) begin
        state <= IDLE;
        carry <= 1'b0;
        cnt   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              a_q   <= NW'(s0);
              b_q   <= NW'(s1);
              carry <= 1'b0;
              cnt   <= '0;
              state <= ADD;
            end
          end
          ADD: begin
            // Each chunk result enters from the MSB side so chunk 0 lands at bit 0 after N shifts.
            res_q <= NW'({chunk[W-1:0], res_q} >> W);
            a_q   <= a_q >> W;
            b_q   <= b_q >> W;
            carry <= chunk[W];
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              sum   <= K'({chunk[W-1:0], res_q} >> W);
              cout  <= chunk[L];
              state <= DONE;
            end
          end
          DONE: begin
            if (out_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_serial.sv
// Self-checking bench for csa_resolve_serial: directed corner cases followed by a random regression
// checked against a full-width reference addition.
module tb_csa_resolve_serial;

  localparam int unsigned K = 2 + 1024 + 1;
  localparam int unsigned W = 64;
  localparam int unsigned N = (K + W - 1) / W;

  logic         clk;
  logic         rst_n;
  logic         ce;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] s0;
  logic [K-1:0] s1;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] sum;
  logic         cout;

  int total = 0;
  int bad   = 0;

  csa_resolve_serial #(.K(K), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s0        (s0),
    .s1        (s1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [K:0] obs, input logic [K:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [K-1:0] rnd();
    logic [K-1:0] v;
    v = '0;
    for (int i = 0; i < (K + 31) / 32; i++) v = (v << 32) | K'($urandom);
    return v;
  endfunction

  // Reference: plain K+1-bit addition gives {cout, sum}.
  function automatic logic [K:0] ref_add(input logic [K-1:0] a, input logic [K-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic send(input logic [K-1:0] a, input logic [K-1:0] b);
    for (int i = 0; i < 100 && !in_ready; i++) step();
    s0 = a;
    s1 = b;
    in_valid = 1'b1;
    ce = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts enabled edges after accept until out_valid rises, optionally toggling ce.
  task automatic wait_out(input bit rand_ce, output int lat);
    bit e;
    lat = 0;
    for (int i = 0; i < 400 && !out_valid; i++) begin
      if (rand_ce) ce = 1'($urandom_range(0, 1));
      e = ce;
      step();
      if (e) lat++;
    end
    ce = 1'b1;
    chk("out_valid_arrives", (K+1)'(out_valid), (K+1)'(1));
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [K-1:0] a;
    logic [K-1:0] b;
    logic [K-1:0] ones;
    logic [K-1:0] msb;
    int lat;
    int m;
    bit seen;

    ones = '1;
    msb = '0;
    msb[K-1] = 1'b1;
    rst_n = 1'b0; ce = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    s0 = '0; s1 = '0;
    #2;
    chk("reset_in_ready", (K+1)'(in_ready), (K+1)'(1));
    chk("reset_out_valid", (K+1)'(out_valid), (K+1)'(0));
    chk("reset_result", {cout, sum}, '0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Full ripple across every chunk boundary.
    send(ones, K'(1));
    wait_out(1'b0, lat);
    chk("ripple_latency", (K+1)'(lat), (K+1)'(N));
    chk("ripple_result", {cout, sum}, ref_add(ones, K'(1)));
    chk("ripple_result_const", {cout, sum}, {1'b1, {K{1'b0}}});
    take();

    send(K'(5), K'(3));
    wait_out(1'b0, lat);
    chk("basic_5_3", {cout, sum}, (K+1)'(8));
    take();

    send(msb, msb);
    wait_out(1'b0, lat);
    chk("msb_plus_msb", {cout, sum}, {1'b1, {K{1'b0}}});
    take();

    // Back-pressure, ce freeze in DONE, and no capture during the DONE handshake.
    a = rnd(); b = rnd();
    send(a, b);
    wait_out(1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", (K+1)'(out_valid), (K+1)'(1));
      chk("hold_result", {cout, sum}, ref_add(a, b));
    end
    ce = 1'b0; out_ready = 1'b1;
    step();
    chk("ce_low_freezes_done", (K+1)'(out_valid), (K+1)'(1));
    ce = 1'b1; in_valid = 1'b1; s0 = rnd(); s1 = rnd();
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("no_accept_on_handshake", (K+1)'(in_ready), (K+1)'(1));

    // Random ce during ADD.
    a = rnd(); b = rnd();
    send(a, b);
    wait_out(1'b1, lat);
    chk("rand_ce_latency", (K+1)'(lat), (K+1)'(N));
    chk("rand_ce_result", {cout, sum}, ref_add(a, b));
    take();

    // Abort at cnt=8, then a fresh pair.
    send(ones, ones);
    repeat (8) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("abort_idle", (K+1)'(in_ready), (K+1)'(1));
    chk("abort_cleared", {cout, sum}, '0);
    send(K'(1), K'(1));
    wait_out(1'b0, lat);
    chk("after_abort_latency", (K+1)'(lat), (K+1)'(N));
    chk("after_abort_result", {cout, sum}, (K+1)'(2));
    take();

    // clr with in_valid in IDLE: no capture.
    clr = 1'b1; in_valid = 1'b1; s0 = ones; s1 = ones;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_blocks_capture", (K+1)'(in_ready), (K+1)'(1));
    step();
    chk("clr_blocks_capture2", (K+1)'(in_ready), (K+1)'(1));

    // clr with out_ready in DONE drops the result.
    send(ones, ones);
    wait_out(1'b0, lat);
    chk("pre_drop_result", {cout, sum}, ref_add(ones, ones));
    clr = 1'b1; out_ready = 1'b1;
    step();
    clr = 1'b0; out_ready = 1'b0;
    chk("drop_out_valid", (K+1)'(out_valid), (K+1)'(0));
    chk("drop_result", {cout, sum}, '0);

    // Asynchronous reset in the middle of ADD.
    send(K'(7), K'(9));
    wait_out(1'b0, lat);
    take();
    send(rnd(), rnd());
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_in_ready", (K+1)'(in_ready), (K+1)'(1));
    chk("midop_reset_out_valid", (K+1)'(out_valid), (K+1)'(0));
    chk("midop_reset_result", {cout, sum}, '0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < int'(N) + 5; i++) begin
      step();
      seen |= out_valid;
    end
    chk("midop_reset_no_output", (K+1)'(seen), (K+1)'(0));

    // Random regression with gaps, back-pressure and occasional ce toggling.
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) step();
      m = int'($urandom_range(0, 3));
      a = rnd();
      b = rnd();
      if (m == 0) b = ~a;
      else if (m == 1) a = ones;
      send(a, b);
      wait_out($urandom_range(0, 3) == 0, lat);
      chk("rand_latency", (K+1)'(lat), (K+1)'(N));
      chk("rand_result", {cout, sum}, ref_add(a, b));
      repeat ($urandom_range(0, 3)) step();
      chk("rand_result_held", {cout, sum}, ref_add(a, b));
      take();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
